// File: rtl/core_sum_xchg.sv
// Inter-core softmax-denominator exchange: per-core partial-sum FIFOs, lockstep pair-pop add,
// and independent per-core read handshakes. Optional macro SUM_XCHG_SAT_EN saturates the add.
module core_sum_xchg #(
  parameter int bw_psum   = 20,
  parameter int depth     = 4,
  parameter int depth_log = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [bw_psum+3:0]   sum0_in,
  input  logic                 sum0_vld,
  input  logic [bw_psum+3:0]   sum1_in,
  input  logic                 sum1_vld,
  output logic                 full0,
  output logic                 full1,
  input  logic                 rd0,
  input  logic                 rd1,
  output logic [bw_psum+3:0]   total0,
  output logic [bw_psum+3:0]   total1,
  output logic                 rd_vld0,
  output logic                 rd_vld1,
  output logic                 ovf_err,
  output logic                 sum_ovf
);
  localparam int sw = bw_psum + 4;
  localparam logic [depth_log:0] depth_c = (depth_log + 1)'(depth);

  // Index 0 belongs to core 0, index 1 to core 1.
  logic [sw-1:0]        mem_q  [2][depth];
  logic [sw-1:0]        mem_d  [2][depth];
  logic [depth_log-1:0] wptr_q [2];
  logic [depth_log-1:0] wptr_d [2];
  logic [depth_log-1:0] rptr_q [2];
  logic [depth_log-1:0] rptr_d [2];
  logic [depth_log:0]   cnt_q  [2];
  logic [depth_log:0]   cnt_d  [2];
  logic [sw-1:0]        total_q, total_d;
  logic                 rd_vld0_q, rd_vld0_d;
  logic                 rd_vld1_q, rd_vld1_d;
  logic                 ovf_err_q, ovf_err_d;
  logic                 sum_ovf_q, sum_ovf_d;

  logic [sw-1:0] push_data [2];
  logic          push_req  [2];
  logic          push_ok   [2];
  logic          pair_pop;
  logic [sw:0]   raw_sum;
  logic [sw-1:0] sum_val;

  // Handshake: a total is offered while rd_vldN=1 and is consumed on any edge where rdN=1.
  // A pair-pop needs both slots free or being consumed in the same cycle.
  always_comb begin
    push_data[0] = sum0_in;
    push_data[1] = sum1_in;
    push_req[0]  = sum0_vld;
    push_req[1]  = sum1_vld;

    pair_pop = (cnt_q[0] != '0) && (cnt_q[1] != '0) &&
               (!rd_vld0_q || rd0) && (!rd_vld1_q || rd1);

    raw_sum = {1'b0, mem_q[0][rptr_q[0]]} + {1'b0, mem_q[1][rptr_q[1]]};
`ifdef SUM_XCHG_SAT_EN
    sum_val = raw_sum[sw] ? {sw{1'b1}} : raw_sum[sw-1:0];
`else
    sum_val = raw_sum[sw-1:0];
`endif

    ovf_err_d = ovf_err_q;
    for (int c = 0; c < 2; c++) begin
      // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
      push_ok[c] = push_req[c] && ((cnt_q[c] < depth_c) || pair_pop);
      mem_d[c]   = mem_q[c];
      wptr_d[c]  = wptr_q[c];
      rptr_d[c]  = rptr_q[c];
      cnt_d[c]   = cnt_q[c];
      if (push_ok[c]) begin
        mem_d[c][wptr_q[c]] = push_data[c];
        wptr_d[c]           = wptr_q[c] + 1'b1;
      end
      if (pair_pop) begin
        rptr_d[c] = rptr_q[c] + 1'b1;
      end
      if (push_ok[c] && !pair_pop) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end else if (!push_ok[c] && pair_pop) begin
        cnt_d[c] = cnt_q[c] - 1'b1;
      end
      if (push_req[c] && !push_ok[c]) begin
        ovf_err_d = 1'b1;
      end
    end

    total_d   = total_q;
    rd_vld0_d = rd_vld0_q && !rd0;
    rd_vld1_d = rd_vld1_q && !rd1;
    sum_ovf_d = sum_ovf_q;
    if (pair_pop) begin
      total_d   = sum_val;
      rd_vld0_d = 1'b1;
      rd_vld1_d = 1'b1;
      sum_ovf_d = sum_ovf_q | raw_sum[sw];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      total_q   <= '0;
      rd_vld0_q <= 1'b0;
      rd_vld1_q <= 1'b0;
      ovf_err_q <= 1'b0;
      sum_ovf_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      total_q   <= total_d;
      rd_vld0_q <= rd_vld0_d;
      rd_vld1_q <= rd_vld1_d;
      ovf_err_q <= ovf_err_d;
      sum_ovf_q <= sum_ovf_d;
    end
  end

  assign full0   = (cnt_q[0] == depth_c);
  assign full1   = (cnt_q[1] == depth_c);
  assign total0  = total_q;
  assign total1  = total_q;
  assign rd_vld0 = rd_vld0_q;
  assign rd_vld1 = rd_vld1_q;
  assign ovf_err = ovf_err_q;
  assign sum_ovf = sum_ovf_q;
endmodule

// File: tb/tb_core_sum_xchg.sv
// Directed bench for core_sum_xchg: expected totals are queued when pairs are pushed and
// popped when the DUT presents them; honours SUM_XCHG_SAT_EN in its reference adder.
module tb_core_sum_xchg;
  localparam int SW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] sum0_in, sum1_in;
  logic          sum0_vld, sum1_vld;
  logic          full0, full1;
  logic          rd0, rd1;
  logic [SW-1:0] total0, total1;
  logic          rd_vld0, rd_vld1;
  logic          ovf_err, sum_ovf;

  logic [SW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  core_sum_xchg #(.bw_psum(20), .depth(4), .depth_log(2)) dut (
    .clk(clk), .reset(reset),
    .sum0_in(sum0_in), .sum0_vld(sum0_vld),
    .sum1_in(sum1_in), .sum1_vld(sum1_vld),
    .full0(full0), .full1(full1),
    .rd0(rd0), .rd1(rd1),
    .total0(total0), .total1(total1),
    .rd_vld0(rd_vld0), .rd_vld1(rd_vld1),
    .ovf_err(ovf_err), .sum_ovf(sum_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] ref_sum(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef SUM_XCHG_SAT_EN
    if (s[SW]) return {SW{1'b1}};
`endif
    return s[SW-1:0];
  endfunction

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one push cycle; a pair with both strobes queues its expected total.
  task automatic push(input logic v0, input logic [SW-1:0] d0,
                      input logic v1, input logic [SW-1:0] d1, input logic expect_pair);
    sum0_vld = v0; sum0_in = d0;
    sum1_vld = v1; sum1_in = d1;
    if (expect_pair) exp_q.push_back(ref_sum(d0, d1));
    tick();
    sum0_vld = 1'b0; sum1_vld = 1'b0;
  endtask

  // Reads both cores every cycle; each cycle must present the next expected total.
  task automatic drain(input string tag, input int budget);
    logic [SW-1:0] e;
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      e = exp_q.pop_front();
      chk({tag, "_vld0"}, 32'(rd_vld0), 32'd1);
      chk({tag, "_vld1"}, 32'(rd_vld1), 32'd1);
      chk({tag, "_total0"}, 32'(total0), 32'(e));
      chk({tag, "_total1"}, 32'(total1), 32'(e));
      rd0 = 1'b1; rd1 = 1'b1;
      tick();
      n++;
    end
    rd0 = 1'b0; rd1 = 1'b0;
    chk({tag, "_budget_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle_vld0"}, 32'(rd_vld0), 32'd0);
    chk({tag, "_idle_vld1"}, 32'(rd_vld1), 32'd0);
  endtask

  initial begin
    logic [SW-1:0] e;
    logic [SW-1:0] a, b;
    reset = 1'b1; sum0_in = '0; sum1_in = '0; sum0_vld = 1'b0; sum1_vld = 1'b0;
    rd0 = 1'b0; rd1 = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_full0", 32'(full0), 32'd0);
    chk("rst_full1", 32'(full1), 32'd0);
    chk("rst_vld0", 32'(rd_vld0), 32'd0);
    chk("rst_vld1", 32'(rd_vld1), 32'd0);
    chk("rst_total0", 32'(total0), 32'd0);
    chk("rst_total1", 32'(total1), 32'd0);
    chk("rst_ovf_err", 32'(ovf_err), 32'd0);
    chk("rst_sum_ovf", 32'(sum_ovf), 32'd0);

    // Basic pair: no bypass, then visible one cycle later
    push(1'b1, 24'h000010, 1'b1, 24'h000020, 1'b1);
    chk("basic_nobypass", 32'(rd_vld0), 32'd0);
    tick();
    drain("basic", 4);

    // Skewed arrival
    push(1'b1, 24'd5, 1'b0, 24'd0, 1'b0);
    tick();
    chk("skew_wait1", 32'(rd_vld0 | rd_vld1), 32'd0);
    tick();
    chk("skew_wait2", 32'(rd_vld0 | rd_vld1), 32'd0);
    exp_q.push_back(ref_sum(24'd5, 24'd7));
    push(1'b0, 24'd0, 1'b1, 24'd7, 1'b0);
    chk("skew_wait3", 32'(rd_vld0 | rd_vld1), 32'd0);
    tick();
    drain("skew", 4);

    // Backpressure: nobody reads, FIFOs fill, extra push dropped
    for (int i = 1; i <= 5; i++) push(1'b1, SW'(i), 1'b1, SW'(i), 1'b1);
    chk("bp_full0", 32'(full0), 32'd1);
    chk("bp_full1", 32'(full1), 32'd1);
    chk("bp_no_ovf_yet", 32'(ovf_err), 32'd0);
    e = exp_q.pop_front();
    chk("bp_first_total", 32'(total0), 32'(e));
    push(1'b1, 24'd6, 1'b1, 24'd6, 1'b0);
    chk("bp_ovf_err", 32'(ovf_err), 32'd1);
    chk("bp_still_full0", 32'(full0), 32'd1);
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    chk("bp_vld0_cleared", 32'(rd_vld0), 32'd0);
    chk("bp_vld1_held", 32'(rd_vld1), 32'd1);
    chk("bp_total_held", 32'(total1), 32'(e));
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
    drain("bp", 8);
    chk("bp_full0_after", 32'(full0), 32'd0);

    // Reload on continuous read, random values
    for (int i = 0; i < 4; i++) begin
      a = SW'($urandom_range(0, 32'hFFFF));
      b = SW'($urandom_range(0, 32'hFFFF));
      push(1'b1, a, 1'b1, b, 1'b1);
    end
    drain("reload", 8);

    // Carry out of the adder
    push(1'b1, 24'hFFFFF0, 1'b1, 24'h000020, 1'b1);
    tick();
    chk("ovf_sum_ovf", 32'(sum_ovf), 32'd1);
`ifdef SUM_XCHG_SAT_EN
    chk("ovf_total_sat", 32'(total0), 32'hFFFFFF);
`else
    chk("ovf_total_wrap", 32'(total0), 32'h000010);
`endif
    drain("ovf", 4);

    // Reset mid-operation
    push(1'b1, 24'd1, 1'b1, 24'd2, 1'b0);
    push(1'b1, 24'd11, 1'b0, 24'd0, 1'b0);
    push(1'b1, 24'd12, 1'b0, 24'd0, 1'b0);
    push(1'b1, 24'd13, 1'b0, 24'd0, 1'b0);
    chk("pre_rst_vld0", 32'(rd_vld0), 32'd1);
    chk("pre_rst_ovf_err", 32'(ovf_err), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("mid_rst_vld0", 32'(rd_vld0), 32'd0);
    chk("mid_rst_vld1", 32'(rd_vld1), 32'd0);
    chk("mid_rst_total", 32'(total0), 32'd0);
    chk("mid_rst_full0", 32'(full0), 32'd0);
    chk("mid_rst_ovf_err", 32'(ovf_err), 32'd0);
    chk("mid_rst_sum_ovf", 32'(sum_ovf), 32'd0);
    push(1'b1, 24'h000100, 1'b1, 24'h000200, 1'b1);
    tick();
    drain("post_rst", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
